// File: rtl/fir_out_serializer.sv
// FIR output serializer: captures 32-bit result words into a small FIFO and
// streams them out LSB byte first over a valid/ready byte interface.
module fir_out_serializer #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            y_dat,
  input  logic                         y_vld,
  output logic [BYTE_W-1:0]            out_byte,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         out_last,
  output logic                         ovf,
  input  logic                         clr_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

  localparam int unsigned NB = DATA_W / BYTE_W;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [IW-1:0]       idx_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]       rd_q, rd_d;
  logic [PW-1:0]       wr_q, wr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic                hs;
  logic                fin;
  logic                pop;
  logic                push;
  logic                drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX) return '0;
    return p + PW'(1);
  endfunction

  // Handshake decode, FIFO pop/push/drop decisions and next pointer/count/flag.
  // Pop is decided from the pre-write count, so a full FIFO can still accept
  // a word on the edge where the serializer takes its head.
  always_comb begin
    hs    = (state_q == SEND) && out_rdy;
    fin   = hs && (idx_q == LAST_IDX);
    pop   = (cnt_q != '0) && ((state_q == IDLE) || fin);
    push  = y_vld && ((cnt_q != FULL_CNT) || pop);
    drop  = y_vld && !push;

    rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = push ? ptr_inc(wr_q) : wr_q;

    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);

    // A drop on the same edge as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
  end

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= y_dat;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Serializer FSM: load from FIFO head, shift out one byte per handshake,
  // chain straight into the next word when one is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_q];
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (fin) begin
            idx_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_q];
            end else begin
              shift_q <= '0;
              state_q <= IDLE;
            end
          end else if (hs) begin
            shift_q <= shift_q >> BYTE_W;
            idx_q   <= idx_q + IW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          shift_q <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign out_byte = shift_q[BYTE_W-1:0];
  assign out_vld  = (state_q == SEND);
  assign out_last = (state_q == SEND) && (idx_q == LAST_IDX);
  assign ovf      = ovf_q;
  assign fifo_cnt = cnt_q;

endmodule

// File: doc/fir_out_serializer.md
Name: fir_out_serializer

Overview:
- Downstream stage of the FIR core. Captures each 32-bit filter output word when the core flags it valid.
- Buffers captured words in a small FIFO and streams them out as bytes, LSB first, over an 8-bit valid/ready interface that drives the pad-side byte bus.
- Lets the top level present the full 32-bit result on 8 pins instead of truncating to the low 16 bits.
- Flags dropped samples through a sticky overflow bit.

Parameters:
- DATA_W, 32, width of the FIR output word; must be a multiple of BYTE_W.
- BYTE_W, 8, width of the output byte bus.
- DEPTH, 2, FIFO depth in words, excluding the serializer shift register; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- y_dat  in  DATA_W  FIR output word; valid only in a cycle where y_vld=1.
- y_vld  in  1  single-cycle strobe: y_dat holds a new sample.
- out_byte  out  BYTE_W  current output byte.
- out_vld  out  1  out_byte is valid.
- out_rdy  in  1  consumer accepts out_byte this cycle.
- out_last  out  1  high with the final (most significant) byte of a word.
- ovf  out  1  sticky flag: at least one sample was dropped.
- clr_ovf  in  1  synchronous clear of ovf.
- fifo_cnt  out  $clog2(DEPTH+1)  number of words held in the FIFO (status only).

Behaviour:
- Reset (rst_n=0, asynchronous): the following clear immediately:
  - out_byte=0, out_vld=0, out_last=0, ovf=0, fifo_cnt=0.
  - Byte index=0; FSM returns to IDLE.
  - Any partially sent word is discarded.
- Release of reset is synchronised externally; the block needs no deassert sync of its own.
- FIFO:
  - Write when y_vld=1 and (fifo_cnt<DEPTH or a pop occurs on the same edge).
  - Pop when the serializer loads a word.
  - Order is strictly first-in, first-out.
- Overflow: y_vld=1 while fifo_cnt==DEPTH with no same-edge pop → the word is dropped and ovf is set.
  - ovf stays set until clr_ovf=1 at an edge.
  - If a set and clr_ovf=1 occur on the same edge, set wins and ovf stays 1.
- FSM states:
  - IDLE: out_vld=0. If fifo_cnt>0, pop the head into the shift register, byte index=0, go to SEND.
  - SEND: out_vld=1, out_byte=shift_reg[BYTE_W-1:0], out_last=(index==DATA_W/BYTE_W-1).
    - On out_vld&&out_rdy with index not final: shift right by BYTE_W and increment index.
    - On out_vld&&out_rdy with index final: if fifo_cnt>0 (evaluated before any same-edge write), load the next word and stay in SEND with index=0, giving back-to-back words with no bubble. Otherwise go to IDLE.
- Latency:
  - y_vld in cycle N with the FIFO empty and the FSM idle → word written at the end of N, loaded at the end of N+1, out_vld=1 during N+2.
  - With out_rdy held high, one byte transfers per cycle.
- Backpressure: while out_vld=1 and out_rdy=0, out_byte, out_last and the index hold stable. The consumer may drop out_rdy at any time.
- Same-edge y_vld and pop: both happen; fifo_cnt is unchanged.
- Capacity before the first drop is DEPTH words in the FIFO plus 1 in the shift register.
- out_byte is driven from a register (no combinational path from y_dat); out_vld and out_last are decoded from registered state.

Test Plan:
- Reset, then y_vld pulse with y_dat=0x12345678, out_rdy=1 → out_vld rises 2 cycles after the pulse; bytes 0x78, 0x56, 0x34, 0x12 on consecutive cycles; out_last=1 on 0x12 only; then out_vld=0.
- Same word, out_rdy toggling 1,0,0,1,1,0,1 → each byte is held stable while out_rdy=0; the sequence is still 78, 56, 34, 12; exactly 4 handshakes; no byte is lost or duplicated.
- y_vld pulses 0xAABBCCDD then 0x01020304 on consecutive cycles, out_rdy=1 → 8 bytes DD, CC, BB, AA, 04, 03, 02, 01 with no gap between words; out_last on AA and 01; fifo_cnt returns to 0.
- out_rdy=0; four y_vld pulses with words W0..W3 → W0 is in the shift register, W1 and W2 are in the FIFO (fifo_cnt=2), W3 is dropped and ovf=1. Raise out_rdy → W0, W1, W2 bytes only. clr_ovf=1 → ovf=0 next cycle.
- FIFO full; y_vld on the same edge as the final-byte handshake that pops → the word is accepted, fifo_cnt stays 2, ovf stays 0. Separately: clr_ovf=1 on the same edge as an overflow drop → ovf=1.
- Assert rst_n=0 mid-word (after byte 2, FIFO holding 1 word) → out_vld, out_last, out_byte, fifo_cnt and ovf are 0 immediately, without waiting for a clock edge. After release, a new word 0xCAFEF00D streams as 0D, F0, FE, CA with nothing left over from before the reset.
